// File: rtl/baud_cfg_if.sv
// Requester-side bus of the baud configuration controller: level requests with
// packed 17-bit baud slices, plus the one-hot ack pulse and its error flag.
interface baud_cfg_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req;
  logic [NREQ*17-1:0]   req_baud;
  logic [NREQ-1:0]      ack;
  logic                 err;

  modport master (output req, output req_baud, input ack, input err);
  modport slave  (input req, input req_baud, output ack, output err);
endinterface

// File: rtl/baud_cfg_ctrl.sv
// Arbitrates baud-change requests onto the shared TX clock generator with a
// drain / hold / settle sequence. Optional macro BAUD_DRAIN_TIMEOUT_EN bounds the drain wait.
module baud_cfg_ctrl #(
  parameter int NREQ          = 4,
  parameter int DEFAULT_BAUD  = 9600,
  parameter int HOLD_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int DRAIN_TIMEOUT = 65535
) (
  input  logic         clk,
  input  logic         rst,
  baud_cfg_if.slave    bus,
  input  logic         link_busy,
  output logic         gen_rst,
  output logic [16:0]  gen_baud,
  output logic [16:0]  cur_baud,
  output logic         cfg_busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || HOLD_CYCLES < 1 || SETTLE_CYCLES < 1 || DRAIN_TIMEOUT < 1)
    begin : g_bad_param
      $error("baud_cfg_ctrl: parameter out of range");
    end

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_CHECK, S_DRAIN, S_HOLD, S_SETTLE, S_ACK
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr, win, win_q;
  logic            any_req;
  logic [16:0]     baud_q;
  logic [31:0]     cnt;
  logic            from_init;
  logic [NREQ-1:0] onehot;

  function automatic logic supported(input logic [16:0] b);
    case (b)
      17'd4800, 17'd9600, 17'd14400, 17'd19200, 17'd38400, 17'd57600: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Scan downward so the requester closest above ptr is the last one written.
  always_comb begin
    win     = ptr;
    any_req = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req[idx]) begin
        win     = PW'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_INIT;
      gen_rst   <= 1'b1;
      gen_baud  <= 17'(DEFAULT_BAUD);
      cur_baud  <= 17'(DEFAULT_BAUD);
      bus.ack   <= '0;
      bus.err   <= 1'b0;
      cfg_busy  <= 1'b1;
      ptr       <= '0;
      win_q     <= '0;
      baud_q    <= 17'(DEFAULT_BAUD);
      cnt       <= '0;
      from_init <= 1'b1;
    end else begin
      bus.ack <= '0;
      bus.err <= 1'b0;
      case (state)
        S_INIT, S_HOLD: begin
          if (cnt == 32'(HOLD_CYCLES - 1)) begin
            cnt      <= '0;
            gen_rst  <= 1'b0;
            cur_baud <= gen_baud;
            state    <= S_SETTLE;
          end else cnt <= cnt + 1'b1;
        end
        S_IDLE: if (any_req) begin
          win_q    <= win;
          baud_q   <= bus.req_baud[17*int'(win) +: 17];
          ptr      <= next_ptr(win);
          cfg_busy <= 1'b1;
          state    <= S_CHECK;
        end
        S_CHECK: begin
          if (!supported(baud_q)) begin
            bus.ack <= onehot;
            bus.err <= 1'b1;
            state   <= S_ACK;
          end else if (baud_q == cur_baud) begin
            bus.ack <= onehot;
            state   <= S_ACK;
          end else begin
            cnt   <= '0;
            state <= S_DRAIN;
          end
        end
        // gen_baud is only ever loaded here, together with raising gen_rst.
        S_DRAIN: begin
          if (!link_busy) begin
            gen_baud <= baud_q;
            gen_rst  <= 1'b1;
            cnt      <= '0;
            state    <= S_HOLD;
          end
`ifdef BAUD_DRAIN_TIMEOUT_EN
          else if (cnt == 32'(DRAIN_TIMEOUT - 1)) begin
            cnt     <= '0;
            bus.ack <= onehot;
            bus.err <= 1'b1;
            state   <= S_ACK;
          end else cnt <= cnt + 1'b1;
`endif
        end
        S_SETTLE: begin
          if (cnt == 32'(SETTLE_CYCLES - 1)) begin
            cnt <= '0;
            if (from_init) begin
              from_init <= 1'b0;
              cfg_busy  <= 1'b0;
              state     <= S_IDLE;
            end else begin
              bus.ack <= onehot;
              state   <= S_ACK;
            end
          end else cnt <= cnt + 1'b1;
        end
        S_ACK: begin
          cfg_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: doc/baud_cfg_ctrl.md
Name: baud_cfg_ctrl

Overview:
- Shares the single TX clock generator between up to NREQ requesters that want to change the baud rate.
- Round-robin arbitrates requests and validates the requested baud against the supported set.
- Waits for the serial link to go idle, then drives the generator's reset and baud inputs through a safe hold/settle sequence.
- Acknowledges the winning requester with a success or error status.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DEFAULT_BAUD, 9600, baud applied after reset.
- HOLD_CYCLES, 2, cycles gen_rst is held high during a switch (>=1).
- SETTLE_CYCLES, 4, cycles after gen_rst release before ack (>=1).
- DRAIN_TIMEOUT, 65535, max cycles spent waiting for link idle (feature-gated).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester change request, level, held until its ack.
- req_baud  in  NREQ*17  packed requested baud; slice i = bits [17*i+16:17*i].
- ack  out  NREQ  one-hot, single-cycle completion pulse to the granted requester.
- err  out  1  valid with ack: 1 = unsupported baud or timeout, no change made.
- link_busy  in  1  high while the TX shifter is mid-frame.
- gen_rst  out  1  active-high reset to the clock generator.
- gen_baud  out  17  baud value driven to the clock generator.
- cur_baud  out  17  baud currently in effect.
- cfg_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (async assert):
  - gen_rst=1, gen_baud=DEFAULT_BAUD, cur_baud=DEFAULT_BAUD.
  - ack=0, err=0, cfg_busy=1.
  - Round-robin pointer=0, state=INIT.
- Supported bauds: 4800, 9600, 14400, 19200, 38400, 57600. Any other value is unsupported.
- States:
  - INIT: gen_rst=1 for HOLD_CYCLES, then SETTLE (no ack issued on exit; goes to IDLE).
  - IDLE: cfg_busy=0. If any req bit is high at a rising edge, latch winner index and its req_baud, then go to CHECK.
  - CHECK: one cycle.
    - Unsupported baud -> ACK with err=1.
    - Latched baud == cur_baud -> ACK with err=0, no generator disturbance.
    - Otherwise -> DRAIN.
  - DRAIN: on the first edge where link_busy=0, load gen_baud <= latched baud and go to HOLD. If link_busy=0 on entry, leave after one cycle.
  - HOLD: gen_rst=1 for exactly HOLD_CYCLES cycles, then SETTLE.
  - SETTLE: gen_rst=0. cur_baud <= gen_baud on entry. Count SETTLE_CYCLES, then ACK (from INIT: go to IDLE instead).
  - ACK: ack[winner]=1 and err valid for one cycle, then IDLE.
- Arbitration:
  - Round-robin starting at the pointer index, searching upward with wrap.
  - After a grant to i, pointer = (i+1) mod NREQ; this applies for error and skip grants too.
- Requester protocol: deassert req in the cycle after ack. A req still high in IDLE is treated as a new request.
- Request changes after latching:
  - req dropped or req_baud changed after latching: ignored; the latched operation completes and ack still pulses.
  - New requests arriving while cfg_busy=1 wait; they are not lost while held high.
- Latency, link idle, change path: ack high 8 cycles after the sampling edge with default parameters (1 CHECK + 1 DRAIN + HOLD + SETTLE). Skip/error path: ack high 1 cycle after the sampling edge.
- gen_baud changes only in DRAIN→HOLD, so it never changes while gen_rst=0.
- Reset mid-operation: all state is lost, the sequence restarts from INIT with DEFAULT_BAUD, and no ack is issued for the aborted request.

Optional Feature:
- Macro BAUD_DRAIN_TIMEOUT_EN.
- Defined:
  - DRAIN counts cycles. If link_busy is still high after DRAIN_TIMEOUT cycles, go to ACK with err=1.
  - gen_baud and cur_baud are unchanged; the pointer advances.
- Undefined: DRAIN waits indefinitely. The counter and DRAIN_TIMEOUT logic are absent.

Test Plan:
- Reset release, no req -> gen_rst high 2 cycles, then low. gen_baud=cur_baud=9600. cfg_busy falls after SETTLE.
- req[1]=1, baud 19200, link idle -> gen_baud=19200 loaded, gen_rst high 2 cycles, ack[1] pulses 8 cycles after sampling, err=0, cur_baud=19200.
- req[0]=1, baud 12345 -> ack[0] one cycle after sampling, err=1, gen_rst never asserts, cur_baud unchanged.
- req[0], req[2], req[3] held simultaneously, pointer=0 -> grant order 0, 2, 3. Then re-request 0 and 3 -> 0 then 3.
- req[2] at 57600 with link_busy=1 for 20 cycles -> gen_baud and gen_rst untouched until link_busy falls. The HOLD/SETTLE sequence follows, then ack[2].
- With BAUD_DRAIN_TIMEOUT_EN and DRAIN_TIMEOUT=10, link_busy stuck high -> ack with err=1 after 10 DRAIN cycles, cur_baud unchanged. Separately, rst low mid-HOLD -> gen_rst=1, gen_baud=9600, no ack.
